// File: rtl/l2_assoc_cache.sv
// l2_assoc_cache: N-way set-associative, write-back, write-allocate L2 cache.
// Holds the tag/valid/dirty/data arrays, hit detection, tree pseudo-LRU
// replacement and the miss FSM that handles writeback and fill.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   mem_address/read/write/wdata line request from the L1 arbiter (held until mem_resp)
//   mem_rdata, mem_resp          read line and one-cycle completion pulse
//   pmem_address/read/write      line-aligned physical memory request
//   pmem_wdata, pmem_rdata       victim line out, fill line in
//   pmem_resp                    physical memory completion pulse
//   hit_count, miss_count        performance counters
//
// Optional feature: define L2_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise both counter outputs are tied to zero.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a request; registers address/op/wdata
// CHECK     | tag compare; hit -> RESPOND, miss -> WRITEBACK or FILL
// RESPOND   | mem_resp pulse for one cycle
// WRITEBACK | dirty victim line written to pmem
// FILL      | requested line read from pmem into the victim way
module l2_assoc_cache #(
  parameter int WAYS      = 8,
  parameter int SETS      = 8,
  parameter int LINE_BITS = 128,
  parameter int IDX_BITS  = $clog2(SETS),
  parameter int TAG_BITS  = 12 - IDX_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [15:0]          mem_address,
  input  logic                 mem_read,
  input  logic                 mem_write,
  input  logic [LINE_BITS-1:0] mem_wdata,
  output logic [LINE_BITS-1:0] mem_rdata,
  output logic                 mem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output logic [LINE_BITS-1:0] pmem_wdata,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);
  localparam int WAY_BITS = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, CHECK, RESPOND, WRITEBACK, FILL} state_t;
  state_t state, state_nxt;

  logic [TAG_BITS-1:0]  tag_arr   [WAYS][SETS];
  logic [LINE_BITS-1:0] data_arr  [WAYS][SETS];
  logic [WAYS-1:0]      valid_arr [SETS];
  logic [WAYS-1:0]      dirty_arr [SETS];
  logic [WAYS-2:0]      plru_arr  [SETS];

  logic [11:0]          req_line;
  logic                 req_write;
  logic [LINE_BITS-1:0] req_wdata;
  logic [WAY_BITS-1:0]  victim_q;
  logic [IDX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]  req_tag;

  // Byte offset within a line never affects the cache.
  logic addr_offset_unused;
  assign addr_offset_unused = ^mem_address[3:0];

  assign req_idx = req_line[IDX_BITS-1:0];
  assign req_tag = req_line[11:IDX_BITS];

  logic                hit;
  logic [WAY_BITS-1:0] hit_way;
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_arr[req_idx][w] && (tag_arr[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  // PLRU node bit = 1 means the victim lies in the right subtree.
  // Nodes are stored heap-style: children of node n are 2n+1 and 2n+2.
  logic [WAY_BITS-1:0] plru_way;
  logic [WAY_BITS-1:0] victim_sel;
  always_comb begin
    int   node;
    logic b;
    node     = 0;
    b        = 1'b0;
    plru_way = '0;
    for (int l = 0; l < WAY_BITS; l++) begin
      b                         = plru_arr[req_idx][node];
      plru_way[WAY_BITS-1-l]    = b;
      node                      = 2 * node + 1 + int'(b);
    end
    // Lowest-index invalid way wins over the PLRU choice.
    victim_sel = plru_way;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[req_idx][w]) victim_sel = WAY_BITS'(w);
    end
  end

  // Point every node on the hit way's path away from it.
  logic [WAYS-2:0] plru_upd;
  always_comb begin
    int   node;
    logic b;
    node     = 0;
    b        = 1'b0;
    plru_upd = plru_arr[req_idx];
    for (int l = 0; l < WAY_BITS; l++) begin
      b              = hit_way[WAY_BITS-1-l];
      plru_upd[node] = ~b;
      node           = 2 * node + 1 + int'(b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: if (mem_read || mem_write) state_nxt = CHECK;
      CHECK: begin
        if (hit)
          state_nxt = RESPOND;
        else if (valid_arr[req_idx][victim_sel] && dirty_arr[req_idx][victim_sel])
          state_nxt = WRITEBACK;
        else
          state_nxt = FILL;
      end
      RESPOND: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[victim_q][req_idx], req_idx, 4'h0};
        pmem_wdata   = data_arr[victim_q][req_idx];
        if (pmem_resp) state_nxt = FILL;
      end
      FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, req_idx, 4'h0};
        if (pmem_resp) state_nxt = CHECK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_line  <= '0;
      req_write <= 1'b0;
      req_wdata <= '0;
      victim_q  <= '0;
      mem_rdata <= '0;
    end else begin
      case (state)
        IDLE: if (mem_read || mem_write) begin
          req_line  <= mem_address[15:4];
          req_write <= mem_write;
          req_wdata <= mem_wdata;
        end
        CHECK: begin
          if (hit && !req_write) mem_rdata <= data_arr[hit_way][req_idx];
          if (!hit) victim_q <= victim_sel;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        CHECK: if (hit) begin
          plru_arr[req_idx] <= plru_upd;
          if (req_write) dirty_arr[req_idx][hit_way] <= 1'b1;
        end
        WRITEBACK: if (pmem_resp) dirty_arr[req_idx][victim_q] <= 1'b0;
        FILL: if (pmem_resp) begin
          valid_arr[req_idx][victim_q] <= 1'b1;
          dirty_arr[req_idx][victim_q] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == CHECK && hit && req_write) begin
      data_arr[hit_way][req_idx] <= req_wdata;
    end else if (state == FILL && pmem_resp) begin
      data_arr[victim_q][req_idx] <= pmem_rdata;
      tag_arr[victim_q][req_idx]  <= req_tag;
    end
  end

`ifdef L2_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        retry;

  // The CHECK that follows a fill always hits; it is not a new hit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      retry      <= 1'b0;
    end else begin
      if (state == FILL && pmem_resp) retry <= 1'b1;
      else if (state == CHECK)        retry <= 1'b0;
      if (state == CHECK) begin
        if (hit && !retry && hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
        if (!hit && miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_l2_assoc_cache.sv
module tb_l2_assoc_cache;
  localparam int WAYS = 8;
  localparam int SETS = 8;

  logic         clk;
  logic         rst;
  logic [15:0]  mem_address;
  logic         mem_read, mem_write;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read, pmem_write;
  logic [127:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count, miss_count;

  l2_assoc_cache #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk(clk), .rst(rst),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Physical memory: answers 3 cycles after a strobe is first seen.
  logic [127:0] pmem_store [4096];
  int           rd_cnt = 0, wb_cnt = 0, ev_cnt = 0, rd_seq = 0, wb_seq = 0;
  logic [15:0]  last_rd_addr, last_wb_addr;
  logic [127:0] last_wb_data;
  int           pc;

  initial begin
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    pc = 0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst) pc = 0;
      else if (pmem_read || pmem_write) begin
        pc++;
        if (pc == 3) begin
          pc = 0;
          pmem_resp = 1'b1;
          ev_cnt++;
          if (pmem_write) begin
            pmem_store[pmem_address[15:4]] = pmem_wdata;
            last_wb_addr = pmem_address;
            last_wb_data = pmem_wdata;
            wb_cnt++;
            wb_seq = ev_cnt;
          end else begin
            pmem_rdata   = pmem_store[pmem_address[15:4]];
            last_rd_addr = pmem_address;
            rd_cnt++;
            rd_seq = ev_cnt;
          end
        end
      end else pc = 0;
    end
  end

  // Reference model: flat memory image plus which lines the cache holds.
  // PLRU is modelled through per-way access times: at each tree node the
  // victim lies in the half whose most recent access is older.
  logic [127:0] gold [4096];
  bit           m_valid [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  int           m_tag   [SETS][WAYS];
  longint       m_ts    [SETS][WAYS];
  longint       tick;
  logic [31:0]  e_hit, e_miss;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 0; m_dirty[s][w] = 0; m_tag[s][w] = 0; m_ts[s][w] = 0;
      end
    for (int i = 0; i < 4096; i++) gold[i] = pmem_store[i];
    tick = 0; e_hit = 0; e_miss = 0;
  endtask

  function automatic int pick_victim(int idx);
    int lo, size, half, res;
    longint ml, mr;
    bit found;
    found = 0; res = 0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!m_valid[idx][w]) begin found = 1; res = w; end
    if (!found) begin
      lo = 0; size = WAYS;
      while (size > 1) begin
        half = size / 2; ml = 0; mr = 0;
        for (int w = 0; w < half; w++) begin
          if (m_ts[idx][lo + w] > ml) ml = m_ts[idx][lo + w];
          if (m_ts[idx][lo + half + w] > mr) mr = m_ts[idx][lo + half + w];
        end
        if (ml > mr) lo += half;
        size = half;
      end
      res = lo;
    end
    return res;
  endfunction

  task automatic access(input logic [15:0] addr, input bit wr, input logic [127:0] wd,
                        input string tag, output int lat_o, output logic [127:0] rdata_o);
    int idx, tg, way, lat, exp_lat, rd0, wb0;
    bit hit, exp_wb, got;
    logic [15:0]  exp_wb_addr;
    logic [127:0] exp_wb_data;
    idx = int'(addr[6:4]);
    tg  = int'(addr[15:7]);
    hit = 0; way = 0; exp_wb = 0; exp_lat = 2;
    exp_wb_addr = '0; exp_wb_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[idx][w] && m_tag[idx][w] == tg) begin hit = 1; way = w; end
    if (!hit) begin
      way = pick_victim(idx);
      exp_lat = 6;
      if (m_valid[idx][way] && m_dirty[idx][way]) begin
        exp_wb = 1; exp_lat = 9;
        exp_wb_addr = 16'((m_tag[idx][way] << 7) | (idx << 4));
        exp_wb_data = gold[(m_tag[idx][way] << 3) | idx];
      end
      m_valid[idx][way] = 1; m_dirty[idx][way] = 0; m_tag[idx][way] = tg;
      if (e_miss != 32'hFFFF_FFFF) e_miss++;
    end else if (e_hit != 32'hFFFF_FFFF) e_hit++;
    tick++;
    m_ts[idx][way] = tick;
    if (wr) begin m_dirty[idx][way] = 1; gold[addr[15:4]] = wd; end

    rd0 = rd_cnt; wb0 = wb_cnt;
    @(negedge clk);
    mem_address = addr; mem_read = !wr; mem_write = wr;
    mem_wdata = wr ? wd : {4{$urandom()}};
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      check({tag, "_strobe_excl"}, pmem_read & pmem_write, 1'b0);
      if (mem_resp) got = 1;
      else begin
        // Registered copy must be used: wiggle address and data mid-flight.
        mem_address = 16'($urandom());
        mem_wdata   = {4{$urandom()}};
      end
    end
    check({tag, "_resp_seen"}, got, 1'b1);
    check({tag, "_latency"}, lat, exp_lat);
    rdata_o = mem_rdata;
    lat_o = lat;
    if (!wr) check({tag, "_rdata"}, mem_rdata, gold[addr[15:4]]);
    @(negedge clk);
    mem_read = 0; mem_write = 0; mem_address = 16'($urandom());
    @(posedge clk); #1;
    check({tag, "_resp_pulse"}, mem_resp, 1'b0);
    check({tag, "_wb_count"}, wb_cnt - wb0, exp_wb ? 1 : 0);
    check({tag, "_rd_count"}, rd_cnt - rd0, hit ? 0 : 1);
    if (exp_wb) begin
      check({tag, "_wb_addr"}, last_wb_addr, exp_wb_addr);
      check({tag, "_wb_data"}, last_wb_data, exp_wb_data);
    end
    if (!hit) check({tag, "_rd_addr"}, last_rd_addr, {addr[15:4], 4'h0});
`ifdef L2_PERF_CNT_EN
    check({tag, "_hit_count"}, hit_count, e_hit);
    check({tag, "_miss_count"}, miss_count, e_miss);
`else
    check({tag, "_hit_count"}, hit_count, 32'd0);
    check({tag, "_miss_count"}, miss_count, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; mem_read = 0; mem_write = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  localparam logic [127:0] L55 = {16{8'h55}};
  localparam logic [127:0] LA5 = {16{8'hA5}};

  initial begin
    int lat;
    logic [127:0] rd;
    int wb0;
    bit got;
    rst = 1; mem_read = 0; mem_write = 0; mem_address = '0; mem_wdata = '0;
    for (int i = 0; i < 4096; i++) pmem_store[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    pmem_store[12'h123] = LA5;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_resp", mem_resp, 1'b0);
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_pmem_address", pmem_address, 16'h0);
    check("rst_pmem_wdata", pmem_wdata, 128'h0);
    check("rst_mem_rdata", mem_rdata, 128'h0);
    check("rst_hit_count", hit_count, 32'h0);
    check("rst_miss_count", miss_count, 32'h0);
    do_reset();

    access(16'h1230, 0, '0, "cold_rd", lat, rd);
    check("cold_rd_addr", last_rd_addr, 16'h1230);
    check("cold_rd_data", rd, LA5);
    check("cold_rd_lat", lat, 6);
    access(16'h1235, 0, '0, "rep_rd", lat, rd);
    check("rep_rd_lat", lat, 2);
`ifdef L2_PERF_CNT_EN
    check("rep_rd_hits", hit_count, 32'd1);
    check("rep_rd_misses", miss_count, 32'd1);
`endif
    access(16'h1230, 1, L55, "wr_hit", lat, rd);
    access(16'h1230, 0, '0, "wr_hit_rd", lat, rd);
    check("wr_hit_rd_data", rd, L55);

    // Dirty eviction after sequential fill of set 3.
    do_reset();
    for (int k = 0; k < 8; k++) access(16'(16'h0030 + k * 16'h80), 1, L55, "dirty_fill", lat, rd);
    access(16'h0430, 0, '0, "dirty_evict", lat, rd);
    check("dirty_evict_addr", last_wb_addr, 16'h0030);
    check("dirty_evict_data", last_wb_data, L55);
    check("dirty_evict_order", wb_seq < rd_seq, 1'b1);
    check("dirty_evict_rd_addr", last_rd_addr, 16'h0430);

    // Clean eviction: no writeback expected.
    do_reset();
    for (int k = 0; k < 8; k++) access(16'(16'h0030 + k * 16'h80), 0, '0, "clean_fill", lat, rd);
    wb0 = wb_cnt;
    access(16'h0430, 0, '0, "clean_evict", lat, rd);
    check("clean_evict_no_wb", wb_cnt - wb0, 0);

    // Reset during writeback.
    do_reset();
    for (int k = 0; k < 8; k++) access(16'(16'h0030 + k * 16'h80), 1, L55, "abort_fill", lat, rd);
    wb0 = wb_cnt;
    @(negedge clk);
    mem_address = 16'h0430; mem_read = 1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(posedge clk); #1;
      if (pmem_write) got = 1;
    end
    check("abort_wb_seen", got, 1'b1);
    @(posedge clk); #2;
    rst = 1; #1;
    check("abort_pmem_write", pmem_write, 1'b0);
    check("abort_pmem_read", pmem_read, 1'b0);
    check("abort_pmem_address", pmem_address, 16'h0);
    check("abort_mem_resp", mem_resp, 1'b0);
    @(negedge clk); mem_read = 0;
    @(negedge clk); rst = 0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check("abort_idle_resp", mem_resp, 1'b0);
    end
    check("abort_no_wb", wb_cnt - wb0, 0);
    for (int k = 0; k < 9; k++) begin
      access(16'(16'h0030 + k * 16'h80), 0, '0, "abort_after", lat, rd);
      check("abort_after_miss_lat", lat, 6);
    end

    // Random traffic over a few sets and a dozen tags.
    do_reset();
    for (int n = 0; n < 300; n++) begin
      logic [15:0] a;
      a = {9'(($urandom_range(0, 11) * 37) & 9'h1FF), 3'($urandom_range(0, 3)), 4'($urandom())};
      access(a, $urandom_range(0, 2) == 0, {$urandom(), $urandom(), $urandom(), $urandom()},
             "rand", lat, rd);
    end

`ifdef L2_PERF_CNT_EN
    do_reset();
    access(16'h1230, 0, '0, "sat_fill", lat, rd);
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    e_hit = 32'hFFFF_FFFE;
    for (int k = 0; k < 3; k++) access(16'h1230, 0, '0, "sat_hit", lat, rd);
    check("sat_hit_final", hit_count, 32'hFFFF_FFFF);
`else
    check("nocnt_hit_final", hit_count, 32'h0);
    check("nocnt_miss_final", miss_count, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
